// File: rtl/refresh_seq.sv
// -----------------------------------------------------------------------------
// refresh_seq
//   DRAM refresh cycle sequencer. Takes the level refresh request from the
//   request block, arbitrates for the DRAM bus and runs CAS-before-RAS refresh
//   cycles on both banks. It returns a one-cycle ack per completed refresh and
//   an opportunistic startref pulse when the bus goes idle.
//
// Handshake: refreq is a level held while refreshes are pending. rreq asks the
//   arbiter for the bus. A refresh starts only on a cycle where refreq, bgnt and
//   mem_idle are all high. Once started, the refresh is atomic and runs to the
//   end of precharge. ack is the only completion indication. It is a single-cycle
//   pulse and is never high on two consecutive cycles.
//
// Ports:
//   clk        system clock, rising edge
//   resetl     asynchronous active-low reset
//   refreq     refresh request (level)
//   bgnt       DRAM bus grant
//   mem_idle   memory controller has no cycle in flight
//   other_req  another master is requesting memory
//   rreq       bus request to arbiter
//   rasl[1:0]  active-low RAS per bank
//   casl[1:0]  active-low CAS per bank
//   ack        one refresh completed (pulse)
//   startref   idle-bus opportunity (pulse)
//   refactive  sequencer owns the bus
//   refcnt     completed refresh count, wraps
//   state_dbg  current FSM state (IDLE=0 WAIT=1 CSR=2 RAS=3 PRE=4)
// -----------------------------------------------------------------------------
module refresh_seq #(
  parameter int T_CSR = 1,
  parameter int T_RAS = 4,
  parameter int T_RP  = 3,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          resetl,
  input  logic          refreq,
  input  logic          bgnt,
  input  logic          mem_idle,
  input  logic          other_req,
  output logic          rreq,
  output logic [1:0]    rasl,
  output logic [1:0]    casl,
  output logic          ack,
  output logic          startref,
  output logic          refactive,
  output logic [CW-1:0] refcnt,
  output logic [2:0]    state_dbg
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_CSR  = 3'd2,
    ST_RAS  = 3'd3,
    ST_PRE  = 3'd4
  } state_t;

  // The down-counter is loaded with T-1 so that each phase lasts exactly T cycles.
  localparam logic [3:0] CSR_LOAD = 4'(T_CSR - 1);
  localparam logic [3:0] RAS_LOAD = 4'(T_RAS - 1);
  localparam logic [3:0] RP_LOAD  = 4'(T_RP - 1);

  state_t     state, nstate;
  logic [3:0] tcnt, ntcnt;
  logic       mem_idle_q;
  logic       can_start;
  logic       ras_done;

  assign can_start = refreq & bgnt & mem_idle;
  assign ras_done  = (state == ST_RAS) && (tcnt == 4'd0);
  assign state_dbg = state;

  always_comb begin
    nstate = state;
    ntcnt  = tcnt;
    case (state)
      ST_IDLE: begin
        if (can_start) begin
          nstate = ST_CSR;
          ntcnt  = CSR_LOAD;
        end else if (refreq) begin
          nstate = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A withdrawn request wins over a late grant. Starting a refresh
        // nobody is waiting for would push the request block's count out of step.
        if (!refreq) begin
          nstate = ST_IDLE;
        end else if (bgnt && mem_idle) begin
          nstate = ST_CSR;
          ntcnt  = CSR_LOAD;
        end
      end
      ST_CSR: begin
        if (tcnt == 4'd0) begin
          nstate = ST_RAS;
          ntcnt  = RAS_LOAD;
        end else begin
          ntcnt = tcnt - 4'd1;
        end
      end
      ST_RAS: begin
        if (tcnt == 4'd0) begin
          nstate = ST_PRE;
          ntcnt  = RP_LOAD;
        end else begin
          ntcnt = tcnt - 4'd1;
        end
      end
      ST_PRE: begin
        if (tcnt == 4'd0) begin
          // Back-to-back refresh goes straight to CSR without an IDLE gap.
          if (can_start) begin
            nstate = ST_CSR;
            ntcnt  = CSR_LOAD;
          end else if (refreq) begin
            nstate = ST_WAIT;
          end else begin
            nstate = ST_IDLE;
          end
        end else begin
          ntcnt = tcnt - 4'd1;
        end
      end
      default: begin
        nstate = ST_IDLE;
        ntcnt  = 4'd0;
      end
    endcase
  end

  // Every output is registered from the next state. Because of this, the strobes
  // change on the same edge as the state change.
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      state      <= ST_IDLE;
      tcnt       <= 4'd0;
      mem_idle_q <= 1'b1;  // a mem_idle already high at reset release is not a rise
      rreq       <= 1'b0;
      rasl       <= 2'b11;
      casl       <= 2'b11;
      ack        <= 1'b0;
      startref   <= 1'b0;
      refactive  <= 1'b0;
      refcnt     <= '0;
    end else begin
      state      <= nstate;
      tcnt       <= ntcnt;
      mem_idle_q <= mem_idle;
      rreq       <= (nstate != ST_IDLE);
      refactive  <= (nstate == ST_CSR) || (nstate == ST_RAS) || (nstate == ST_PRE);
      casl       <= ((nstate == ST_CSR) || (nstate == ST_RAS)) ? 2'b00 : 2'b11;
      rasl       <= (nstate == ST_RAS) ? 2'b00 : 2'b11;
      ack        <= ras_done;
      if (ras_done) begin
        refcnt <= refcnt + CW'(1);
      end
      startref   <= (state == ST_IDLE) && mem_idle && !mem_idle_q &&
                    !other_req && !refreq;
    end
  end

  // A zero timing parameter would make the load value wrap to 15.
  always @(posedge clk) begin
    assert (T_CSR >= 1 && T_CSR <= 15 && T_RAS >= 1 && T_RAS <= 15 &&
            T_RP >= 1 && T_RP <= 15)
      else $error("refresh_seq: timing parameters must be in 1..15");
  end

endmodule

// File: tb/tb_refresh_seq.sv
module tb_refresh_seq;

  localparam int EW = 24;  // {rreq, rasl, casl, ack, startref, refactive, refcnt}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetl = 1'b0;
  always #5 clk = ~clk;

  logic refreq = 1'b0, bgnt = 1'b0, mem_idle = 1'b0, other_req = 1'b0;
  logic rreq, ack, startref, refactive;
  logic [1:0] rasl, casl;
  logic [15:0] refcnt;
  logic [2:0] state_dbg;

  logic rreq4, ack4, startref4, refactive4;
  logic [1:0] rasl4, casl4;
  logic [3:0] refcnt4;
  logic [2:0] state_dbg4;

  refresh_seq dut (
    .clk(clk), .resetl(resetl), .refreq(refreq), .bgnt(bgnt),
    .mem_idle(mem_idle), .other_req(other_req), .rreq(rreq), .rasl(rasl),
    .casl(casl), .ack(ack), .startref(startref), .refactive(refactive),
    .refcnt(refcnt), .state_dbg(state_dbg)
  );

  refresh_seq #(.CW(4)) dut4 (
    .clk(clk), .resetl(resetl), .refreq(refreq), .bgnt(bgnt),
    .mem_idle(mem_idle), .other_req(other_req), .rreq(rreq4), .rasl(rasl4),
    .casl(casl4), .ack(ack4), .startref(startref4), .refactive(refactive4),
    .refcnt(refcnt4), .state_dbg(state_dbg4)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // f = {rreq, ras_low, cas_low, ack, startref, refactive}
  function automatic logic [EW-1:0] exp_w(input logic [5:0] f, input logic [15:0] cnt);
    return {f[5], f[4] ? 2'b00 : 2'b11, f[3] ? 2'b00 : 2'b11, f[2], f[1], f[0], cnt};
  endfunction

  // Expected outputs p edges after CSR entry (p=0..7) of a default 1/4/3 refresh.
  function automatic logic [EW-1:0] ph_exp(input int p, input logic [15:0] base);
    logic [5:0] f;
    f = {1'b1, (p >= 1 && p <= 4), (p <= 4), (p == 5), 1'b0, 1'b1};
    return exp_w(f, base + ((p >= 5) ? 16'd1 : 16'd0));
  endfunction

  function automatic logic [EW-1:0] act_w();
    return {rreq, rasl, casl, ack, startref, refactive, refcnt};
  endfunction

  // ---------------- driver ----------------
  // Drive on the falling edge, push the expectation, then compare 1ns after the rising edge.
  task automatic step(input logic [3:0] in_v, input logic [EW-1:0] exp_v, input string name);
    logic [EW-1:0] e;
    @(negedge clk);
    {refreq, bgnt, mem_idle, other_req} = in_v;
    exp_q.push_back(exp_v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check(name, 32'(act_w()), 32'(e));
  endtask

  typedef struct {
    logic [3:0] in_v;   // {refreq, bgnt, mem_idle, other_req}
    logic [5:0] f;      // {rreq, ras_low, cas_low, ack, startref, refactive}
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[18];
  logic idle_seen;

  initial begin
    // startref edge detection, then one full default refresh with atomicity
    tbl[0]  = '{4'b0000, 6'b000000, 16'd0};
    tbl[1]  = '{4'b0010, 6'b000010, 16'd0};  // mem_idle rise -> startref
    tbl[2]  = '{4'b0010, 6'b000000, 16'd0};  // single pulse
    tbl[3]  = '{4'b0001, 6'b000000, 16'd0};
    tbl[4]  = '{4'b0011, 6'b000000, 16'd0};  // other_req suppresses
    tbl[5]  = '{4'b0001, 6'b000000, 16'd0};
    tbl[6]  = '{4'b1110, 6'b101001, 16'd0};  // CSR; refreq suppresses startref
    tbl[7]  = '{4'b0110, 6'b111001, 16'd0};  // RAS 1, refreq dropped
    tbl[8]  = '{4'b0000, 6'b111001, 16'd0};  // RAS 2, bgnt/mem_idle lost
    tbl[9]  = '{4'b0000, 6'b111001, 16'd0};  // RAS 3
    tbl[10] = '{4'b0100, 6'b111001, 16'd0};  // RAS 4
    tbl[11] = '{4'b0000, 6'b100101, 16'd1};  // PRE 1, ack, count
    tbl[12] = '{4'b0010, 6'b100001, 16'd1};  // PRE 2
    tbl[13] = '{4'b0010, 6'b100001, 16'd1};  // PRE 3
    tbl[14] = '{4'b0010, 6'b000000, 16'd1};  // IDLE
    tbl[15] = '{4'b0000, 6'b000000, 16'd1};
    tbl[16] = '{4'b0010, 6'b000010, 16'd1};  // startref again in IDLE
    tbl[17] = '{4'b0010, 6'b000000, 16'd1};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'(act_w()), 32'(exp_w(6'b000000, 16'd0)));
    check("reset_state", 32'(state_dbg), 32'd0);
    @(negedge clk);
    resetl = 1'b1;

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].in_v, exp_w(tbl[i].f, tbl[i].cnt), $sformatf("tbl_%0d", i));
    end

    // three back-to-back refreshes, no IDLE in between
    idle_seen = 1'b0;
    for (int e = 0; e < 24; e++) begin
      step(4'b1110, ph_exp(e % 8, 16'(1 + e / 8)), $sformatf("b2b_%0d", e));
      if (state_dbg == 3'd0) idle_seen = 1'b1;
    end
    step(4'b0010, exp_w(6'b000000, 16'd4), "b2b_end");
    check("b2b_no_idle", 32'(idle_seen), 32'd0);
    check("b2b_end_state", 32'(state_dbg), 32'd0);

    // no grant for 10 cycles: WAIT with rreq and no strobes
    for (int w = 0; w < 10; w++) begin
      step(4'b1000, exp_w(6'b100000, 16'd4), $sformatf("wait_%0d", w));
    end
    check("wait_state", 32'(state_dbg), 32'd1);
    step(4'b1110, ph_exp(0, 16'd4), "grant_csr");
    step(4'b0110, ph_exp(1, 16'd4), "grant_p1");
    for (int p = 2; p <= 4; p++) step(4'b0000, ph_exp(p, 16'd4), $sformatf("grant_p%0d", p));
    for (int p = 5; p <= 7; p++) step(4'b0010, ph_exp(p, 16'd4), $sformatf("grant_p%0d", p));
    step(4'b0010, exp_w(6'b000000, 16'd5), "grant_idle");

    // asynchronous reset in the second RAS cycle
    step(4'b1110, ph_exp(0, 16'd5), "rst_csr");
    step(4'b0000, ph_exp(1, 16'd5), "rst_ras1");
    step(4'b0000, ph_exp(2, 16'd5), "rst_ras2");
    #3;
    resetl = 1'b0;
    #1;  // still before the next rising edge
    check("async_rst_outputs", 32'(act_w()), 32'(exp_w(6'b000000, 16'd0)));
    check("async_rst_state", 32'(state_dbg), 32'd0);
    @(negedge clk);
    resetl = 1'b1;
    step(4'b0000, exp_w(6'b000000, 16'd0), "post_rst_no_ack");

    // 17 back-to-back refreshes: 16-bit count reaches 17, 4-bit count wraps to 1
    for (int e = 0; e < 136; e++) begin
      step(4'b1110, ph_exp(e % 8, 16'(e / 8)), $sformatf("wrap_%0d", e));
    end
    step(4'b0010, exp_w(6'b000000, 16'd17), "wrap_end");
    check("cw4_wrap", 32'(refcnt4), 32'd1);

    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
